// File: rtl/mod_add_arbiter.sv
// mod_add_arbiter: four requesters share one modular adder computing (a+b) mod n
// with a single conditional subtraction. Default build uses fixed priority
// (requester 0 highest). Define MOD_ADD_ARB_RR_EN for round-robin arbitration.
//
// state | meaning
// IDLE  | waiting for a request; grant is combinational in this state
// CALC  | captured operands are reduced and the result is registered
// RESP  | result presented until resp_ready
module mod_add_arbiter #(
  parameter int W = 256
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  output logic [3:0]     req_ready,
  input  logic [4*W-1:0] req_a,
  input  logic [4*W-1:0] req_b,
  input  logic [4*W-1:0] req_n,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [1:0]     resp_id,
  output logic [W-1:0]   resp_q,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t       state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] n_r;
  logic [1:0]   g_r;
  logic [1:0]   pick;
  logic         take;
  logic [W:0]   sum;
  logic [W-1:0] diff;
  logic [W-1:0] red;

`ifdef MOD_ADD_ARB_RR_EN
  logic [1:0]   last_g;
  logic [1:0]   cand;
`endif

  // Arbitration: the lowest-ranked pending requester is overwritten by higher ranks
  always_comb begin
    pick = 2'd0;
`ifdef MOD_ADD_ARB_RR_EN
    cand = 2'd0;
    // k=4 wraps back onto last_g itself, which therefore ranks lowest
    for (int k = 4; k >= 1; k--) begin
      cand = last_g + 2'(k);
      if (req_valid[cand]) pick = cand;
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (req_valid[i]) pick = 2'(i);
    end
`endif
  end

  // Grant handshake is visible only in IDLE and never while reset is asserted
  always_comb begin
    take      = (state == IDLE) && !rst && (|req_valid);
    req_ready = take ? (4'b0001 << pick) : 4'b0000;
    busy      = (state != IDLE);
  end

  // Single conditional subtraction; the carry bit of the sum joins the compare
  always_comb begin
    sum  = {1'b0, a_r} + {1'b0, b_r};
    diff = sum[W-1:0] - n_r;
    red  = (sum >= {1'b0, n_r}) ? diff : sum[W-1:0];
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_q     <= '0;
      resp_id    <= 2'd0;
      a_r        <= '0;
      b_r        <= '0;
      n_r        <= '0;
      g_r        <= 2'd0;
`ifdef MOD_ADD_ARB_RR_EN
      last_g     <= 2'd3;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            a_r   <= req_a[int'(pick)*W +: W];
            b_r   <= req_b[int'(pick)*W +: W];
            n_r   <= req_n[int'(pick)*W +: W];
            g_r   <= pick;
`ifdef MOD_ADD_ARB_RR_EN
            last_g <= pick;
`endif
            state <= CALC;
          end
        end
        CALC: begin
          resp_q     <= red;
          resp_id    <= g_r;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mod_add_arbiter.md
MOD_ADD_ARBITER -- requirements
Module: mod_add_arbiter

Interface
REQ-001 Parameter W, default 256: operand/modulus width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  4  per-requester request strobe; requester i uses bit i.
REQ-005 req_ready  output  4  per-requester grant/accept, one-hot or zero.
REQ-006 req_a  input  4*W  operand a; requester i at bits [i*W +: W].
REQ-007 req_b  input  4*W  operand b; same packing as req_a.
REQ-008 req_n  input  4*W  modulus n; same packing as req_a.
REQ-009 resp_valid  output  1  result available.
REQ-010 resp_ready  input  1  result consumer accept.
REQ-011 resp_id  output  2  index of the requester that owns resp_q.
REQ-012 resp_q  output  W  result (a+b) mod n.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 Three states SHALL exist: IDLE, CALC, RESP.
REQ-015 IDLE: if any req_valid, arbiter SHALL pick one index g, drive req_ready[g]=1 combinationally in that cycle, capture a, b, n and g into internal registers, and go to CALC; otherwise req_ready=0 and the state stays IDLE.
REQ-016 req_ready SHALL be 0 in CALC and RESP.
REQ-017 CALC: the block SHALL form the W+1-bit sum s=a+b, set result = s-n if s>=n, else s, register it into resp_q, register g into resp_id, and go to RESP.
REQ-018 Comparison SHALL be >= (s==n yields 0), and the carry bit W of s SHALL take part in the compare.
REQ-019 Only one conditional subtraction SHALL be done: for a,b<n the result is fully reduced; otherwise the result is s or s-n truncated to W bits, with no error flag.
REQ-020 RESP: resp_valid=1 and resp_q/resp_id SHALL hold stable until resp_ready=1; on that edge the block SHALL go to IDLE.
REQ-021 A new grant SHALL NOT occur in the same cycle as the resp_ready acceptance; minimum issue interval is 3 cycles (grant, CALC, accept).
REQ-022 A requester dropping req_valid while not granted SHALL have no effect.
REQ-023 Operands SHALL be sampled only at the grant cycle; later changes on req_a/req_b/req_n SHALL NOT affect the result.
REQ-024 Round-robin mode keeps a 2-bit pointer last_g; priority order SHALL be last_g+1, last_g+2, ... (mod 4); last_g SHALL be updated to g at each grant.

Reset
REQ-025 While rst=1 at a clock edge: state=IDLE, resp_valid=0, resp_q=0, resp_id=0, last_g=3, and internal operand registers=0.
REQ-026 req_ready SHALL be 0 while rst=1, and busy SHALL be 0 after the reset edge.
REQ-027 Reset in CALC or RESP SHALL abandon the operation, with no response issued for it.

Configuration
REQ-028 Macro MOD_ADD_ARB_RR_EN defined: round-robin arbitration per REQ-024.
REQ-029 Macro MOD_ADD_ARB_RR_EN undefined: fixed priority, with requester 0 highest and 3 lowest; last_g SHALL be absent or unused. All other behaviour SHALL be identical.

Verification
REQ-030 Test 1: W=256, n=FFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_7203DF6B_21C6052B_53BBF409_39D54123, a=n-1, b=1, requester 2 only -> req_ready=4'b0100 in cycle 0, resp_valid in cycle 2, resp_q=0, resp_id=2.
REQ-031 Test 2: a=n-1, b=n-1 (carry case) -> resp_q=n-2. Also a=5, b=7, n=100 -> resp_q=12.
REQ-032 Test 3: req_valid=4'b1111 held with resp_ready=1 -> RR build grants 0,1,2,3,0 with a spacing of 3 cycles; without the macro, grants are 0,0,0.
REQ-033 Test 4: resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_q and resp_id stay stable, req_ready stays 0, then 1 cycle after resp_ready=1 the block is in IDLE and can grant.
REQ-034 Test 5: rst pulsed while in CALC -> next cycle resp_valid=0, busy=0, and the first grant after reset goes to requester 0 with all requests pending.
REQ-035 Test 6: req_a changed the cycle after grant -> result reflects the value sampled at grant.
